// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A producer hands over one byte at a time via a valid/ready handshake; all outputs are flops.
module uart_tx #(
    parameter int ClkFreq   = 10_000_000,
    parameter int BaudRate  = 115200,
    parameter int ParityEn  = 0,
    parameter int ParityOdd = 0,
    parameter int StopBits  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int ClksPerBit = ClkFreq / BaudRate;
    localparam int CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(ClksPerBit - 1);
    localparam logic StopLast  = (StopBits == 2) ? 1'b1 : 1'b0;
    localparam logic ParityUse = (ParityEn != 0) ? 1'b1 : 1'b0;
    localparam logic OddSel    = (ParityOdd != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t          state_r, state_s;
    logic [CntW-1:0] baud_r, baud_s;
    logic [2:0]      bit_r, bit_s, bit_nxt_s;
    logic            stop_r, stop_s;
    logic [7:0]      data_r, data_s;
    logic            tx_r, tx_s;
    logic            ready_r, ready_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            bit_end_s;

    // Next-state, counters and next output values; the line level is precomputed so o_tx comes straight from a flop.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_s     = bit_r;
        stop_s    = stop_r;
        data_s    = data_r;
        tx_s      = tx_r;
        ready_s   = ready_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        bit_end_s = (baud_r == BaudLast);
        bit_nxt_s = bit_r + 3'd1;

        case (state_r)
            IDLE: begin
                tx_s    = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
                baud_s  = '0;
                bit_s   = 3'd0;
                stop_s  = 1'b0;
                if (i_tx_valid && ready_r) begin
                    data_s  = i_tx_byte;
                    state_s = START;
                    tx_s    = 1'b0;
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    tx_s    = data_r[0];
                end else begin
                    baud_s = baud_r + CntW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (bit_r == 3'd7) begin
                        if (ParityUse) begin
                            state_s = PARITY;
                            tx_s    = parity_bit(data_r, OddSel);
                        end else begin
                            state_s = STOP;
                            tx_s    = 1'b1;
                        end
                    end else begin
                        bit_s = bit_nxt_s;
                        tx_s  = data_r[bit_nxt_s];
                    end
                end else begin
                    baud_s = baud_r + CntW'(1);
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_s = STOP;
                    baud_s  = '0;
                    tx_s    = 1'b1;
                end else begin
                    baud_s = baud_r + CntW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (stop_r == StopLast) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                        ready_s = 1'b1;
                        busy_s  = 1'b0;
                        tx_s    = 1'b1;
                    end else begin
                        stop_s = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + CntW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
                bit_s   = 3'd0;
                stop_s  = 1'b0;
                tx_s    = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            stop_r  <= 1'b0;
            data_r  <= 8'h00;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            stop_r  <= stop_s;
            data_r  <= data_s;
            tx_r    <= tx_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign o_tx       = tx_r;
    assign o_tx_ready = ready_r;
    assign o_tx_busy  = busy_r;
    assign o_tx_done  = done_r;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises bytes onto `o_tx`. It is the transmit-side counterpart of the existing `uart_rx` in the board top and uses the same `ClkFreq`/`BaudRate` parameterisation. A producer hands it one byte at a time over a valid/ready handshake. Frame format is start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.

Parameters:
- `ClkFreq`, default 10_000_000: `i_clk` frequency in Hz.
- `BaudRate`, default 115200: line rate in bit/s. `ClksPerBit = ClkFreq / BaudRate`, integer division, truncated (86 at the defaults).
- `ParityEn`, default 0: 1 inserts a parity bit after the data bits.
- `ParityOdd`, default 0: 0 selects even parity, 1 selects odd. Ignored when `ParityEn` = 0.
- `StopBits`, default 1: number of stop bits, legal values 1 or 2.

Ports:
- `i_clk`  input  1  system clock
- `i_rst`  input  1  synchronous, active-high reset
- `i_tx_valid`  input  1  producer has a byte on `i_tx_byte`
- `i_tx_byte`  input  8  byte to transmit
- `o_tx_ready`  output  1  block can accept a byte this cycle
- `o_tx`  output  1  serial line, idle high, registered
- `o_tx_busy`  output  1  a frame is in progress
- `o_tx_done`  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: `o_tx` = 1, `o_tx_ready` = 1, `o_tx_busy` = 0, `o_tx_done` = 0, state IDLE, bit counter 0, baud counter 0.
  - While `i_rst` is high, no byte is accepted.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `o_tx` = 1, `o_tx_ready` = 1, `o_tx_busy` = 0.
  - Acceptance happens at a rising edge where `i_tx_valid` && `o_tx_ready`. At that edge the block latches `i_tx_byte`, moves to START, drops `o_tx_ready` and raises `o_tx_busy`.
- START:
  - `o_tx` = 0 from the first cycle after acceptance.
  - Lasts exactly `ClksPerBit` cycles.
- DATA:
  - 8 bits, LSB first, each exactly `ClksPerBit` cycles.
  - A 3-bit index counts the bits; the state exits after index 7.
- PARITY (only when `ParityEn` = 1):
  - `o_tx` = XOR of the latched byte, inverted if `ParityOdd` = 1.
  - Lasts `ClksPerBit` cycles.
- STOP:
  - `o_tx` = 1 for `StopBits * ClksPerBit` cycles.
  - On the final stop cycle the next state is IDLE.
  - In the following cycle `o_tx_done` = 1 for exactly one cycle, `o_tx_ready` = 1 and `o_tx_busy` = 0.
- Baud counter:
  - Counts 0 to `ClksPerBit-1` and reloads to 0 on every bit boundary.
  - Width is `$clog2(ClksPerBit)`; no wrap occurs inside a bit.
- Latency:
  - With acceptance at edge 0, the start bit occupies cycles 1 to `ClksPerBit`.
  - `o_tx_ready` returns `(1+8+ParityEn+StopBits)*ClksPerBit + 1` cycles after acceptance.
- Back-to-back frames:
  - If `i_tx_valid` is held high, the next byte is accepted in the cycle `o_tx_ready` returns.
  - This gives exactly one idle-high cycle between frames.
  - The same cycle can show `o_tx_done` = 1 and a new acceptance.
- Input stability:
  - `i_tx_valid` while `o_tx_ready` = 0 is ignored, not queued.
  - `i_tx_byte` changes after acceptance have no effect on the frame in progress.
- `o_tx` is driven from a flop only: no combinational path from inputs and no glitches.
- Reset mid-frame:
  - The frame is aborted and `o_tx` = 1 in the cycle after the reset edge.
  - The latched byte is discarded and no `o_tx_done` pulse is produced.
  - `o_tx_ready` = 1 once `i_rst` deasserts.

Test Plan:
1. Basic frame: `ClkFreq`=1_000_000, `BaudRate`=100_000 (`ClksPerBit` = 10). Send 0x55, accepted at cycle 0.
   -> `o_tx` low for cycles 1–10.
   -> Data bits 1,0,1,0,1,0,1,0 at 10 cycles each (cycles 11–90).
   -> High for cycles 91–100.
   -> `o_tx_done` and `o_tx_ready` high at cycle 101.
2. Back-to-back: same configuration, `i_tx_valid` held with 0xA5 then 0x3C.
   -> Second acceptance at cycle 101; second start bit at cycles 102–111.
   -> Exactly one `o_tx_done` pulse per frame; line decodes 0xA5, 0x3C.
3. Parity and stop bits: `ParityEn`=1, byte 0x07.
   -> Even parity: parity bit (cycles 91–100) = 1.
   -> `ParityOdd`=1: parity bit = 0.
   -> With `StopBits`=2: stop high for 20 cycles and `o_tx_ready` at cycle 121.
4. Ignored request: during DATA of a 0x55 frame, pulse `i_tx_valid` with 0xFF and change `i_tx_byte`.
   -> Frame bits unchanged, no second frame, single `o_tx_done`.
5. Reset mid-frame: assert `i_rst` for one cycle during data bit 3.
   -> `o_tx` = 1 the next cycle, `o_tx_busy` = 0, no `o_tx_done`.
   -> `o_tx_ready` = 1 after release; a new 0x81 frame then transmits correctly.
6. Loopback: defaults (10 MHz, 115200), `o_tx` wired to `uart_rx.i_rx`; send 0x00, 0xFF, 0xA3.
   -> `uart_rx` asserts `o_rx_valid` three times with `o_rx_byte` = 0x00, 0xFF, 0xA3.
